timer_entry: RTL and testbench

TIMER_ENTRY -- requirements
Module: timer_entry

---
 rtl/timer_entry.sv | 110 +++++++++++
 tb/tb_timer_entry.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/timer_entry.sv
// Keypad entry controller for a three-digit BCD countdown timer (M:SS).
// Collects digits, validates START and issues a one-cycle active-low load strobe.
module timer_entry (
    input  logic       clock,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       busy,
    output logic       loadn,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] digit_count,
    output logic       err
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 2;

    localparam logic [DW-1:0] MAX_DIGIT = DW'(9);
    localparam logic [DW-1:0] MAX_TENS  = DW'(5);
    localparam logic [DW-1:0] KEY_CLEAR = DW'(10);
    localparam logic [DW-1:0] KEY_START = DW'(11);
    localparam logic [CW-1:0] MAX_COUNT = CW'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] min_ones_nxt, sec_tens_nxt, sec_ones_nxt;
    logic [CW-1:0] count_nxt;
    logic          err_nxt, loadn_nxt;

    // State and all outputs are registered together.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            min_ones    <= '0;
            sec_tens    <= '0;
            sec_ones    <= '0;
            digit_count <= '0;
            err         <= 1'b0;
            loadn       <= 1'b1;
        end else begin
            state       <= state_nxt;
            min_ones    <= min_ones_nxt;
            sec_tens    <= sec_tens_nxt;
            sec_ones    <= sec_ones_nxt;
            digit_count <= count_nxt;
            err         <= err_nxt;
            loadn       <= loadn_nxt;
        end
    end

    // Key decode; loadn_nxt is low exactly when entering LOAD so the strobe spans the LOAD cycle.
    always_comb begin
        state_nxt    = state;
        min_ones_nxt = min_ones;
        sec_tens_nxt = sec_tens;
        sec_ones_nxt = sec_ones;
        count_nxt    = digit_count;
        err_nxt      = 1'b0;
        loadn_nxt    = 1'b1;

        case (state)
            LOAD: begin
                state_nxt    = IDLE;
                min_ones_nxt = '0;
                sec_tens_nxt = '0;
                sec_ones_nxt = '0;
                count_nxt    = '0;
            end
            IDLE, ENTRY: begin
                if (key_valid) begin
                    if (key <= MAX_DIGIT) begin
                        if (busy || digit_count == MAX_COUNT) begin
                            err_nxt = 1'b1;
                        end else begin
                            min_ones_nxt = sec_tens;
                            sec_tens_nxt = sec_ones;
                            sec_ones_nxt = key;
                            count_nxt    = digit_count + CW'(1);
                            state_nxt    = ENTRY;
                        end
                    end else if (key == KEY_CLEAR) begin
                        min_ones_nxt = '0;
                        sec_tens_nxt = '0;
                        sec_ones_nxt = '0;
                        count_nxt    = '0;
                        state_nxt    = IDLE;
                    end else if (key == KEY_START) begin
                        if (state == ENTRY && !busy && sec_tens <= MAX_TENS) begin
                            state_nxt = LOAD;
                            loadn_nxt = 1'b0;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_entry.sv
// Bench for timer_entry: directed scenarios then random keys against a digit-queue reference model.
module tb_timer_entry;

    logic       clock = 1'b0;
    logic       clrn;
    logic       key_valid;
    logic [3:0] key;
    logic       busy;
    logic       loadn;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic [1:0] digit_count;
    logic       err;

    int tests = 0;
    int fails = 0;

    // Reference model: the digits typed so far, oldest first, plus a pending-load flag.
    int q[$];
    bit in_load;
    int exp_err;
    int exp_loadn;

    timer_entry dut (
        .clock      (clock),
        .clrn       (clrn),
        .key_valid  (key_valid),
        .key        (key),
        .busy       (busy),
        .loadn      (loadn),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .digit_count(digit_count),
        .err        (err)
    );

    always #5 clock = ~clock;

    function automatic int digit_at(int from_end);
        if (q.size() > from_end) return q[q.size() - 1 - from_end];
        return 0;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all();
        chk("min_ones", int'(min_ones), digit_at(2));
        chk("sec_tens", int'(sec_tens), digit_at(1));
        chk("sec_ones", int'(sec_ones), digit_at(0));
        chk("digit_count", int'(digit_count), q.size());
        chk("err", int'(err), exp_err);
        chk("loadn", int'(loadn), exp_loadn);
    endtask

    // Apply one cycle of input, advance the model by one clock, then compare.
    task automatic press(input bit kv, input int k, input bit b);
        int tens;
        key_valid = kv;
        key       = 4'(k);
        busy      = b;
        @(posedge clock);
        #1;
        exp_err   = 0;
        exp_loadn = 1;
        if (in_load) begin
            q.delete();
            in_load = 0;
        end else if (kv) begin
            if (k <= 9) begin
                if (b || q.size() == 3) exp_err = 1;
                else q.push_back(k);
            end else if (k == 10) begin
                q.delete();
            end else if (k == 11) begin
                tens = digit_at(1);
                if (q.size() > 0 && !b && tens <= 5) begin
                    in_load   = 1;
                    exp_loadn = 0;
                end else begin
                    exp_err = 1;
                end
            end
        end
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        in_load   = 0;
        exp_err   = 0;
        exp_loadn = 1;
    endtask

    initial begin
        clrn      = 1'b0;
        key_valid = 1'b0;
        key       = 4'h0;
        busy      = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        check_all();
        clrn = 1'b1;

        // 1,3,0 START: load 1/3/0 for one cycle, then clear
        press(1, 1, 0); press(1, 3, 0); press(1, 0, 0);
        press(1, 11, 0);
        press(0, 0, 0);
        press(0, 0, 0);

        // 2,7,5 START rejected, digits kept, CLEAR
        press(1, 2, 0); press(1, 7, 0); press(1, 5, 0);
        press(1, 11, 0);
        press(0, 0, 0);
        press(1, 10, 0);

        // fourth digit rejected, then START loads 4/5/6
        press(1, 4, 0); press(1, 5, 0); press(1, 6, 0); press(1, 8, 0);
        press(1, 11, 0);
        press(0, 0, 0);

        // START in IDLE, digit while busy, CLEAR while busy
        press(1, 11, 0);
        press(1, 9, 1);
        press(1, 10, 1);

        // START while busy rejected, ignored key, key during LOAD ignored
        press(1, 3, 0);
        press(1, 11, 1);
        press(1, 14, 0);
        press(1, 11, 0);
        press(1, 7, 0);
        press(1, 10, 0);

        // reset during LOAD aborts the strobe immediately
        press(1, 5, 0);
        press(1, 11, 0);
        clrn = 1'b0;
        #2;
        model_reset();
        check_all();
        clrn = 1'b1;
        press(1, 8, 0);
        press(1, 10, 0);

        // random keys, busy roughly a quarter of the time
        for (int i = 0; i < 400; i++) begin
            press(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
